// File: rtl/adc_capture.sv
// adc_capture: registers ADC samples, detects rising midpoint crossings with hysteresis,
// and reports period, min and max per waveform period.
module adc_capture #(
    parameter int HYST        = 8,
    parameter int PERIOD_BITS = 24
) (
    input  logic                   clk,
    input  logic                   resetn,
    output logic                   ADC_clk,
    input  logic [7:0]             ADC_data,
    output logic [PERIOD_BITS-1:0] period,
    output logic [7:0]             vmin,
    output logic [7:0]             vmax,
    output logic                   meas_valid,
    output logic                   timeout
);
    localparam logic [7:0] TH_HI = 8'(128 + HYST);
    localparam logic [7:0] TH_LO = 8'(128 - HYST);
    localparam bit         ZERO_BAND = (HYST == 0);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t                 state_q;
    logic [7:0]             sample_q;
    logic                   hi_q;
    logic                   hi_d;
    logic [PERIOD_BITS-1:0] cnt_q;
    logic [7:0]             run_min_q;
    logic [7:0]             run_max_q;
    logic [7:0]             min_d;
    logic [7:0]             max_d;
    logic                   up;
    logic                   dn;
    logic                   rise_evt;

    assign ADC_clk = clk;

    // With a zero band, a sample of exactly 128 must hold the comparator state.
    always_comb begin
        up       = (sample_q >= TH_HI) && !(ZERO_BAND && sample_q == TH_HI);
        dn       = (sample_q <= TH_LO) && !(ZERO_BAND && sample_q == TH_LO);
        hi_d     = hi_q ? !dn : up;
        rise_evt = !hi_q && up;
        min_d    = (sample_q < run_min_q) ? sample_q : run_min_q;
        max_d    = (sample_q > run_max_q) ? sample_q : run_max_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            sample_q   <= '0;
            hi_q       <= 1'b0;
            cnt_q      <= '0;
            run_min_q  <= '0;
            run_max_q  <= '0;
            period     <= '0;
            vmin       <= '0;
            vmax       <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            sample_q   <= ADC_data;
            hi_q       <= hi_d;
            meas_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise_evt) begin
                        cnt_q     <= PERIOD_BITS'(1);
                        run_min_q <= sample_q;
                        run_max_q <= sample_q;
                        state_q   <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise_evt) begin
                        period     <= cnt_q;
                        vmin       <= min_d;
                        vmax       <= max_d;
                        meas_valid <= 1'b1;
                        timeout    <= 1'b0;
                        cnt_q      <= PERIOD_BITS'(1);
                        run_min_q  <= sample_q;
                        run_max_q  <= sample_q;
                    end else if (&cnt_q) begin
                        timeout <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q     <= cnt_q + 1'b1;
                        run_min_q <= min_d;
                        run_max_q <= max_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_capture.sv
// tb_adc_capture: drives directed and random waveforms into a default and an 8-bit-period
// instance and compares every cycle against a crossing-time reference model.
module tb_adc_capture;
    localparam int         HYST  = 8;
    localparam logic [7:0] TH_HI = 8'(128 + HYST);
    localparam logic [7:0] TH_LO = 8'(128 - HYST);

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  ADC_data = 8'd0;
    logic        ck0, ck1, v0, v1, to0, to1;
    logic [23:0] p0;
    logic [7:0]  p1, lo0, hi0, lo1, hi1;

    int          tests = 0;
    int          fails = 0;
    string       phase = "reset";

    logic [7:0]  hist[$];
    logic [7:0]  prev = 8'd0;
    bit          mhi;
    bit          armed[2];
    int          t0[2];
    int          maxp[2] = '{(1 << 24) - 1, 255};
    int          exp_p[2];
    logic [7:0]  exp_lo[2], exp_hi[2];
    logic        exp_v[2], exp_to[2];

    adc_capture dut0 (
        .clk(clk), .resetn(resetn), .ADC_clk(ck0), .ADC_data(ADC_data),
        .period(p0), .vmin(lo0), .vmax(hi0), .meas_valid(v0), .timeout(to0)
    );

    adc_capture #(.HYST(HYST), .PERIOD_BITS(8)) dut1 (
        .clk(clk), .resetn(resetn), .ADC_clk(ck1), .ADC_data(ADC_data),
        .period(p1), .vmin(lo1), .vmax(hi1), .meas_valid(v1), .timeout(to1)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        mhi = 1'b0;
        for (int i = 0; i < 2; i++) begin
            armed[i]  = 1'b0;
            t0[i]     = 0;
            exp_p[i]  = 0;
            exp_lo[i] = 8'd0;
            exp_hi[i] = 8'd0;
            exp_v[i]  = 1'b0;
            exp_to[i] = 1'b0;
        end
    endfunction

    // Outputs are derived from the times of rising crossings and the sample history between them.
    function automatic void model(logic [7:0] s);
        int         t;
        bit         rise;
        logic [7:0] mn, mx;
        hist.push_back(s);
        t = hist.size() - 1;
        rise = !mhi && s >= TH_HI;
        if (rise) mhi = 1'b1;
        else if (s <= TH_LO) mhi = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_v[i] = 1'b0;
            if (rise) begin
                if (armed[i]) begin
                    mn = 8'd255;
                    mx = 8'd0;
                    for (int k = t0[i]; k <= t; k++) begin
                        if (hist[k] < mn) mn = hist[k];
                        if (hist[k] > mx) mx = hist[k];
                    end
                    exp_p[i]  = t - t0[i];
                    exp_lo[i] = mn;
                    exp_hi[i] = mx;
                    exp_v[i]  = 1'b1;
                    exp_to[i] = 1'b0;
                end
                armed[i] = 1'b1;
                t0[i]    = t;
            end else if (armed[i] && t - t0[i] == maxp[i]) begin
                exp_to[i] = 1'b1;
                armed[i]  = 1'b0;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, hist.size(), obs, exp);
        end
    endtask

    task automatic step(input logic [7:0] v);
        ADC_data = v;
        @(posedge clk);
        #1;
        if (!resetn) begin
            model_reset();
            prev = 8'd0;
        end else begin
            model(prev);
            prev = v;
        end
        chk({phase, "/core"}, {22'd0, p0, lo0, hi0, v0, to0},
            {22'd0, 24'(exp_p[0]), exp_lo[0], exp_hi[0], exp_v[0], exp_to[0]});
        chk({phase, "/pb8"}, {38'd0, p1, lo1, hi1, v1, to1},
            {38'd0, 8'(exp_p[1]), exp_lo[1], exp_hi[1], exp_v[1], exp_to[1]});
    endtask

    task automatic square(input logic [7:0] lo, input logic [7:0] hi, input int nlo, input int nhi,
                          input int reps);
        repeat (reps) begin
            repeat (nlo) step(lo);
            repeat (nhi) step(hi);
        end
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        step(8'd0);
        resetn = 1'b1;
    endtask

    initial begin
        model_reset();
        resetn = 1'b0;
        repeat (3) step(8'd0);
        resetn = 1'b1;
        chk("adc_clk", 64'({ck0, ck1}), 64'({clk, clk}));

        phase = "square";
        square(8'd0, 8'd255, 50, 50, 5);

        phase = "rand_square";
        repeat (4) square(8'($urandom_range(0, 119)), 8'($urandom_range(136, 255)),
                          int'($urandom_range(10, 80)), int'($urandom_range(10, 80)), 3);

        phase = "triangle";
        repeat (3)
            for (int k = 0; k < 256; k++) step(8'(k < 128 ? 64 + k : 192 - (k - 128)));

        phase = "hyst";
        pulse_reset();
        repeat (20) begin
            step(8'd135);
            step(8'd121);
        end
        repeat (2) begin
            repeat (5) step(8'd136);
            repeat (5) step(8'd120);
        end

        phase = "pb8";
        square(8'd0, 8'd255, 127, 128, 3);
        square(8'd0, 8'd255, 128, 128, 3);
        square(8'd0, 8'd255, 50, 50, 4);

        phase = "const";
        pulse_reset();
        repeat (300) step(8'd200);

        phase = "midreset";
        square(8'd0, 8'd255, 50, 50, 3);
        repeat (20) step(8'd0);
        pulse_reset();
        repeat (30) step(8'd0);
        square(8'd0, 8'd255, 50, 50, 3);

        phase = "random";
        repeat (400) step(8'($urandom_range(0, 255)));
        repeat (300) step($urandom_range(0, 3) == 0 ? 8'($urandom_range(0, 255)) : prev);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
